// File: rtl/t31_delay_meter_pkg.sv
// Shared types and constants for the delay meter.
package t31_delay_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2,
    WAIT_OFF  = 2'd3
  } state_t;

  // Reported measurement kinds; the numeric value also selects the statistics slot.
  localparam logic [1:0] KIND_RISE = 2'b00;
  localparam logic [1:0] KIND_FALL = 2'b01;
  localparam logic [1:0] KIND_OFF  = 2'b10;

  localparam int unsigned NUM_KINDS = 3;

  // Statistics reset fill: minimums start all-ones, maximums start all-zeros.
  localparam logic STAT_MIN_FILL = 1'b1;
  localparam logic STAT_MAX_FILL = 1'b0;

endpackage

// File: rtl/t31_edge_detect.sv
// Previous-sample register with rise/fall strobes for one synchronous input.
module t31_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev;

  // Remember the value seen at the previous sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;
  assign fall = ~d & prev;

endmodule

// File: rtl/t31_delay_meter.sv
// Measures rise, fall and turn-off delays of a gate under test and keeps per-kind min/max.
module t31_delay_meter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             stim,
  input  logic             ctrl,
  input  logic             resp,
  input  logic             resp_en,
  output logic             busy,
  output logic             meas_valid,
  output logic [1:0]       meas_kind,
  output logic [CNT_W-1:0] meas_delay,
  output logic             timeout,
  output logic [CNT_W-1:0] rise_min,
  output logic [CNT_W-1:0] rise_max,
  output logic [CNT_W-1:0] fall_min,
  output logic [CNT_W-1:0] fall_max,
  output logic [CNT_W-1:0] off_min,
  output logic [CNT_W-1:0] off_max
);

  import t31_delay_meter_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_INIT    = {CNT_W{STAT_MIN_FILL}};
  localparam logic [CNT_W-1:0] MAX_INIT    = {CNT_W{STAT_MAX_FILL}};

  logic stim_rise, stim_fall, ctrl_rise, ctrl_fall;
  logic resp_rise, resp_fall, en_rise, en_fall;

  t31_edge_detect u_stim_ed (.clk(clk), .rst_n(rst_n), .d(stim),    .rise(stim_rise), .fall(stim_fall));
  t31_edge_detect u_ctrl_ed (.clk(clk), .rst_n(rst_n), .d(ctrl),    .rise(ctrl_rise), .fall(ctrl_fall));
  t31_edge_detect u_resp_ed (.clk(clk), .rst_n(rst_n), .d(resp),    .rise(resp_rise), .fall(resp_fall));
  t31_edge_detect u_en_ed   (.clk(clk), .rst_n(rst_n), .d(resp_en), .rise(en_rise),   .fall(en_fall));

  // ctrl falling and resp_en rising carry no meaning for any measurement.
  logic unused_edges;
  assign unused_edges = ctrl_fall ^ en_rise;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             rpt, tmo_hit, wait_hit;
  logic [1:0]       rpt_kind;
  logic [CNT_W-1:0] rpt_delay;

  // Decide this sample's trigger, report or timeout from the current state and edges
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    rpt       = 1'b0;
    rpt_kind  = KIND_RISE;
    rpt_delay = '0;
    tmo_hit   = 1'b0;
    wait_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        // Turn-off is already complete if the driver is released at the trigger sample.
        if (ctrl_rise) begin
          rpt_kind = KIND_OFF;
          if (!resp_en) rpt = 1'b1;
          else begin nxt_state = WAIT_OFF; nxt_cnt = CNT_ONE; end
        end else if (stim_rise) begin
          rpt_kind = KIND_RISE;
          if (resp_rise) rpt = 1'b1;
          else begin nxt_state = WAIT_RISE; nxt_cnt = CNT_ONE; end
        end else if (stim_fall) begin
          rpt_kind = KIND_FALL;
          if (resp_fall) rpt = 1'b1;
          else begin nxt_state = WAIT_FALL; nxt_cnt = CNT_ONE; end
        end
      end
      WAIT_RISE, WAIT_FALL, WAIT_OFF: begin
        if (state == WAIT_RISE) begin
          rpt_kind = KIND_RISE;
          wait_hit = resp_rise;
        end else if (state == WAIT_FALL) begin
          rpt_kind = KIND_FALL;
          wait_hit = resp_fall;
        end else begin
          rpt_kind = KIND_OFF;
          wait_hit = en_fall;
        end
        if (wait_hit) begin
          rpt       = 1'b1;
          rpt_delay = cnt;
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else if (cnt == TIMEOUT_CNT) begin
          tmo_hit   = 1'b1;
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
    endcase
  end

  // Measurement FSM with registered status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      meas_kind  <= KIND_RISE;
      meas_delay <= '0;
    end else if (clear) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      meas_kind  <= KIND_RISE;
      meas_delay <= '0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      busy       <= (nxt_state != IDLE);
      meas_valid <= rpt;
      timeout    <= tmo_hit;
      if (rpt) begin
        meas_kind  <= rpt_kind;
        meas_delay <= rpt_delay;
      end
    end
  end

  for (genvar k = 0; k < NUM_KINDS; k++) begin : g_stat
    logic [CNT_W-1:0] lo, hi;
    logic             upd;

    assign upd = rpt && (rpt_kind == 2'(k));

    // Fold each reported delay of this kind into its running min/max
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lo <= MIN_INIT;
        hi <= MAX_INIT;
      end else if (clear) begin
        lo <= MIN_INIT;
        hi <= MAX_INIT;
      end else if (upd) begin
        if (rpt_delay < lo) lo <= rpt_delay;
        if (rpt_delay > hi) hi <= rpt_delay;
      end
    end
  end

  // Slot index equals the kind code: 0 rise, 1 fall, 2 turn-off.
  assign rise_min = g_stat[0].lo;
  assign rise_max = g_stat[0].hi;
  assign fall_min = g_stat[1].lo;
  assign fall_max = g_stat[1].hi;
  assign off_min  = g_stat[2].lo;
  assign off_max  = g_stat[2].hi;

endmodule

// File: tb/tb_t31_delay_meter.sv
// Self-checking bench for t31_delay_meter: directed table, corner sequences, random vs reference model.
module tb_t31_delay_meter;

  localparam int unsigned CNT_W = 8;
  localparam int          TMO   = 10;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic stim = 1'b0, ctrl = 1'b0, resp = 1'b0, resp_en = 1'b0;
  logic             busy, meas_valid, timeout;
  logic [1:0]       meas_kind;
  logic [CNT_W-1:0] meas_delay, rise_min, rise_max, fall_min, fall_max, off_min, off_max;

  t31_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .stim(stim), .ctrl(ctrl),
    .resp(resp), .resp_en(resp_en), .busy(busy), .meas_valid(meas_valid),
    .meas_kind(meas_kind), .meas_delay(meas_delay), .timeout(timeout),
    .rise_min(rise_min), .rise_max(rise_max), .fall_min(fall_min),
    .fall_max(fall_max), .off_min(off_min), .off_max(off_max)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: pending measurement timed by sample stamps
  int m_now, m_start, m_pkind;
  bit m_pend, m_valid, m_tmo;
  int m_kind, m_delay;
  int mn[3], mx[3];
  bit p_stim, p_ctrl, p_resp, p_en;

  function automatic void m_reset_stats();
    for (int k = 0; k < 3; k++) begin mn[k] = 255; mx[k] = 0; end
  endfunction

  function automatic void model_reset();
    m_pend = 0; m_valid = 0; m_tmo = 0; m_kind = 0; m_delay = 0;
    p_stim = 0; p_ctrl = 0; p_resp = 0; p_en = 0;
    m_reset_stats();
  endfunction

  function automatic void m_report(int k, int d);
    m_valid = 1; m_kind = k; m_delay = d;
    if (d < mn[k]) mn[k] = d;
    if (d > mx[k]) mx[k] = d;
  endfunction

  function automatic void m_start_meas(int k, bit done_now);
    if (done_now) m_report(k, 0);
    else begin m_pend = 1; m_pkind = k; m_start = m_now; end
  endfunction

  function automatic void model_step(bit s, bit c, bit r, bit e, bit clr);
    bit rr, rf, ef, hit;
    int el;
    rr = r && !p_resp; rf = !r && p_resp; ef = !e && p_en;
    m_valid = 0; m_tmo = 0;
    if (clr) begin
      m_pend = 0; m_kind = 0; m_delay = 0; m_reset_stats();
    end else if (m_pend) begin
      el  = m_now - m_start;
      hit = (m_pkind == 0) ? rr : (m_pkind == 1) ? rf : ef;
      if (hit) begin m_pend = 0; m_report(m_pkind, el); end
      else if (el == TMO) begin m_pend = 0; m_tmo = 1; end
    end else begin
      if (c && !p_ctrl)      m_start_meas(2, !e);
      else if (s && !p_stim) m_start_meas(0, rr);
      else if (!s && p_stim) m_start_meas(1, rf);
    end
    p_stim = s; p_ctrl = c; p_resp = r; p_en = e;
    m_now++;
  endfunction

  task automatic chk_model();
    chk("m_busy", busy, m_pend);
    chk("m_valid", meas_valid, m_valid);
    chk("m_timeout", timeout, m_tmo);
    chk("m_kind", meas_kind, m_kind);
    chk("m_delay", meas_delay, m_delay);
    chk("m_rise_min", rise_min, mn[0]); chk("m_rise_max", rise_max, mx[0]);
    chk("m_fall_min", fall_min, mn[1]); chk("m_fall_max", fall_max, mx[1]);
    chk("m_off_min", off_min, mn[2]);   chk("m_off_max", off_max, mx[2]);
  endtask

  // One sample: advance model at the edge, then compare just after it.
  task automatic cyc();
    @(posedge clk);
    model_step(stim, ctrl, resp, resp_en, clear);
    #1;
    chk_model();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);   chk({tag, "_valid"}, meas_valid, 0);
    chk({tag, "_tmo"}, timeout, 0);
    chk({tag, "_rise_min"}, rise_min, 8'hFF); chk({tag, "_rise_max"}, rise_max, 0);
    chk({tag, "_fall_min"}, fall_min, 8'hFF); chk({tag, "_fall_max"}, fall_max, 0);
    chk({tag, "_off_min"}, off_min, 8'hFF);   chk({tag, "_off_max"}, off_max, 0);
  endtask

  // ---------------- directed vector table
  typedef struct packed {
    logic s, c, r, e, clr;
    logic busy, valid, tmo;
    logic [1:0] kind;
    logic [7:0] delay;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic c, logic r, logic e, logic clr,
                              logic b, logic v, logic t, logic [1:0] k, logic [7:0] d);
    vec_t x;
    x.s = s; x.c = c; x.r = r; x.e = e; x.clr = clr;
    x.busy = b; x.valid = v; x.tmo = t; x.kind = k; x.delay = d;
    return x;
  endfunction

  int fd[3];

  initial begin
    model_reset();
    m_now = 0;

    #12;
    chk("rst_kind", meas_kind, 0);
    chk("rst_delay", meas_delay, 0);
    chk_cleared("rst");
    rst_n = 1'b1;

    //             s c r e clr  busy val tmo kind delay
    tbl.push_back(mk(0,0,0,1,0, 0,0,0,2'd0,8'd0));  // 0 idle
    tbl.push_back(mk(1,0,0,1,0, 1,0,0,2'd0,8'd0));  // 1 rise trigger
    tbl.push_back(mk(1,0,0,1,0, 1,0,0,2'd0,8'd0));
    tbl.push_back(mk(1,0,0,1,0, 1,0,0,2'd0,8'd0));
    tbl.push_back(mk(1,0,1,1,0, 0,1,0,2'd0,8'd3));  // 4 rise delay 3
    tbl.push_back(mk(1,0,1,1,0, 0,0,0,2'd0,8'd3));
    tbl.push_back(mk(1,1,1,0,0, 0,1,0,2'd2,8'd0));  // 6 ctrl+resp_en same sample
    tbl.push_back(mk(1,0,1,1,0, 0,0,0,2'd2,8'd0));
    tbl.push_back(mk(0,0,0,1,0, 0,1,0,2'd1,8'd0));  // 8 zero-delay fall
    tbl.push_back(mk(1,1,0,1,0, 1,0,0,2'd1,8'd0));  // 9 ctrl beats stim
    tbl.push_back(mk(0,1,0,1,0, 1,0,0,2'd1,8'd0));  // stim edges ignored in WAIT_OFF
    tbl.push_back(mk(1,1,0,1,0, 1,0,0,2'd1,8'd0));
    tbl.push_back(mk(1,1,0,0,0, 0,1,0,2'd2,8'd3));  // 12 turn-off delay 3
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,2'd2,8'd3));
    tbl.push_back(mk(1,0,1,1,0, 0,0,0,2'd2,8'd3));
    tbl.push_back(mk(1,1,1,1,0, 1,0,0,2'd2,8'd3));  // 15 turn-off trigger
    tbl.push_back(mk(1,1,1,1,0, 1,0,0,2'd2,8'd3));
    tbl.push_back(mk(1,1,1,1,0, 1,0,0,2'd2,8'd3));
    tbl.push_back(mk(1,1,1,1,0, 1,0,0,2'd2,8'd3));
    tbl.push_back(mk(1,1,1,1,0, 1,0,0,2'd2,8'd3));
    tbl.push_back(mk(1,1,1,0,0, 0,1,0,2'd2,8'd5));  // 20 turn-off delay 5
    tbl.push_back(mk(0,1,0,0,0, 0,1,0,2'd1,8'd0));  // zero-delay fall
    tbl.push_back(mk(0,1,1,0,0, 0,0,0,2'd1,8'd0));
    tbl.push_back(mk(1,1,1,0,0, 1,0,0,2'd1,8'd0));  // 23 rise trigger, resp high
    tbl.push_back(mk(1,1,0,0,0, 1,0,0,2'd1,8'd0));  // resp fall ignored
    tbl.push_back(mk(1,1,1,0,0, 0,1,0,2'd0,8'd2));  // 25 rise delay 2
    tbl.push_back(mk(1,1,1,0,0, 0,0,0,2'd0,8'd2));

    for (int i = 0; i < tbl.size(); i++) begin
      stim = tbl[i].s; ctrl = tbl[i].c; resp = tbl[i].r; resp_en = tbl[i].e; clear = tbl[i].clr;
      cyc();
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_valid", meas_valid, tbl[i].valid);
      chk("tbl_timeout", timeout, tbl[i].tmo);
      chk("tbl_kind", meas_kind, tbl[i].kind);
      chk("tbl_delay", meas_delay, tbl[i].delay);
      if (i == 4) begin
        chk("first_rise_min", rise_min, 3);
        chk("first_rise_max", rise_max, 3);
      end
    end
    chk("tbl_rise_min", rise_min, 2); chk("tbl_rise_max", rise_max, 3);
    chk("tbl_off_min", off_min, 0);   chk("tbl_off_max", off_max, 5);

    // clear, then fall delays 4, 2, 6 (each followed by a zero-delay rise to re-arm)
    clear = 1; cyc(); clear = 0;
    chk("clr_kind", meas_kind, 0); chk("clr_delay", meas_delay, 0);
    chk_cleared("clr");
    fd = '{4, 2, 6};
    foreach (fd[j]) begin
      stim = 0; cyc();
      chk("fall_busy", busy, 1);
      repeat (fd[j] - 1) cyc();
      resp = 0; cyc();
      chk("fall_valid", meas_valid, 1); chk("fall_kind", meas_kind, 1);
      chk("fall_delay", meas_delay, fd[j]);
      if (j == 2) begin
        chk("fall_min", fall_min, 2); chk("fall_max", fall_max, 6);
      end
      stim = 1; resp = 1; cyc(); cyc();
    end

    // timeout: stim rise with no response edge
    stim = 0; resp = 0; cyc(); cyc();
    stim = 1; cyc();
    for (int k = 1; k < TMO; k++) begin
      cyc();
      chk("tmo_early", timeout, 0); chk("tmo_busy", busy, 1);
    end
    cyc();
    chk("tmo_pulse", timeout, 1); chk("tmo_valid", meas_valid, 0); chk("tmo_busy_drop", busy, 0);
    chk("tmo_rise_min", rise_min, 0); chk("tmo_rise_max", rise_max, 0);
    cyc();
    chk("tmo_one_cycle", timeout, 0);

    // clear mid-WAIT_RISE
    resp = 1; cyc();
    stim = 0; resp = 0; cyc();
    stim = 1; cyc();
    chk("abort_clr_busy_pre", busy, 1);
    cyc(); cyc();
    clear = 1; stim = 0; cyc(); clear = 0;
    chk_cleared("abort_clr");
    cyc();
    chk("abort_clr_busy_post", busy, 0); chk("abort_clr_valid_post", meas_valid, 0);

    // reset mid-WAIT_FALL
    stim = 1; resp = 1; cyc();
    stim = 0; cyc();
    chk("abort_rst_busy_pre", busy, 1);
    cyc();
    rst_n = 0; #1;
    model_reset();
    chk_cleared("abort_rst");
    ctrl = 0; resp_en = 0;
    #2 rst_n = 1;
    cyc();
    chk("abort_rst_busy_post", busy, 0); chk("abort_rst_valid_post", meas_valid, 0);

    // randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(5) == 0) stim = ~stim;
      if ($urandom_range(9) == 0) ctrl = ~ctrl;
      if ($urandom_range(7) == 0) resp = ~resp;
      if ($urandom_range(4) == 0) resp_en = ~resp_en;
      clear = ($urandom_range(99) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/t31_delay_meter.md
# t31_delay_meter

Synchronous measurement block that characterises the delay behaviour of a gate under test: it watches a stimulus, the gate's response and the gate's output-enable, and measures rise, fall and turn-off delays in clock cycles. It keeps running minimum and maximum values per delay kind, giving a min/max view of each delay. It sits on the observing end of a gated or tristate driver, such as an AND or bufif0 stage, inside a characterisation bench or a self-test wrapper.

## Interface
- CNT_W, 8, width of the delay counter and of every delay/statistic output.
- TIMEOUT, 200, samples to wait for a response before abandoning a measurement; must satisfy 1 ≤ TIMEOUT < 2**CNT_W.

- clk  input  1  sole clock; all inputs are sampled on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous; returns the FSM to IDLE and the statistics to their reset values.
- stim  input  1  stimulus driven into the gate under test.
- ctrl  input  1  driver-disable control; 0→1 requests turn-off.
- resp  input  1  observed gate output; must be already synchronous to clk.
- resp_en  input  1  observed driver-enable; 1 = driving, 0 = released.
- busy  output  1  measurement in progress.
- meas_valid  output  1  one-cycle pulse; the measurement result is valid.
- meas_kind  output  2  00 rise, 01 fall, 10 turn-off.
- meas_delay  output  CNT_W  delay of the reported measurement, in samples.
- timeout  output  1  one-cycle pulse; the measurement was abandoned.
- rise_min, rise_max, fall_min, fall_max, off_min, off_max  output  CNT_W each  running statistics.

## Operation
- Each input has a previous-sample register. An edge at sample k means the value at k differs from the value at k-1.
- States: IDLE, WAIT_RISE, WAIT_FALL, WAIT_OFF.
- IDLE triggers, highest priority first:
  - ctrl 0→1 starts a turn-off measurement.
  - stim 0→1 starts a rise measurement.
  - stim 1→0 starts a fall measurement.
  - Lower-priority triggers in the same sample are dropped.
- Expected response for each kind:
  - Rise: resp 0→1.
  - Fall: resp 1→0.
  - Turn-off: resp_en 1→0, or resp_en sampled 0 at the trigger sample.
- Zero delay: if the expected response occurs in the trigger sample, report delay 0 and stay in IDLE.
- Otherwise enter WAIT_x with cnt=1. At each later sample:
  - If the expected response occurs, report cnt and go to IDLE.
  - Else if cnt==TIMEOUT, pulse timeout, go to IDLE and leave the statistics untouched.
  - Else increment cnt.
- All triggers are ignored while in any WAIT state. There is no queueing.
- Unexpected resp edges while waiting (for example resp 1→0 during WAIT_RISE) are ignored.
- Report: meas_valid=1, meas_kind and meas_delay are set. In the same cycle the min/max of that kind update: min=min(min,d), max=max(max,d).
- meas_kind and meas_delay hold their values until the next report.
- clear has priority over any report in the same cycle. A pending report is discarded and busy drops.

## Timing
- Registered outputs. A response sampled at edge k gives meas_valid high in the cycle after edge k. The updated statistics are visible in that same cycle.
- busy goes high the cycle after the trigger edge, and low together with the meas_valid or timeout pulse.
- A trigger is accepted in the first IDLE cycle after a report, so back-to-back measurements are possible.
- Reset values (rst_n low, asynchronous):
  - State IDLE, cnt 0, all previous-sample registers 0.
  - busy, meas_valid, timeout, meas_kind and meas_delay all 0.
  - All *_min outputs all-ones, all *_max outputs 0.
  - Because stim resets to 0, a stim already high at reset release counts as a rise trigger.
- Reset mid-measurement aborts it without a pulse.
- clear gives the same values as reset, one cycle after clear is sampled.

## Structure
- Package t31_delay_meter_pkg holds:
  - the state enum;
  - the meas_kind codes KIND_RISE, KIND_FALL, KIND_OFF;
  - the statistics reset constants.
- One sub-module, t31_edge_detect. It contains the previous-sample register and produces rise/fall strobes. It is instantiated for stim, ctrl, resp and resp_en.
- Per-kind min/max update logic is a generate loop over the three kinds in the top level.

## Test plan
- Rise delay: stim 0→1, resp 0→1 three cycles later. Expect meas_kind=00 and meas_delay=3. Expect rise_min=rise_max=3.
- Min/max tracking: fall delays of 4, then 2, then 6 cycles. Expect fall_min=2, fall_max=6, and last meas_delay=6.
- Turn-off: ctrl 0→1, resp_en 1→0 five cycles later. Expect kind=10 and delay=5. Also cover ctrl and resp_en edges in the same sample, which must give delay 0 with busy never high.
- Timeout: TIMEOUT=10, stim 0→1 with no resp edge. Expect a timeout pulse exactly 10 samples after the trigger, no meas_valid, and statistics unchanged.
- Priority and overlap:
  - ctrl and stim rise in the same sample: only a turn-off measurement runs.
  - A stim edge during WAIT_OFF: ignored.
  - Unexpected resp edges during WAIT_RISE: ignored.
- Abort: assert clear mid-WAIT_RISE, and separately drop rst_n mid-WAIT_FALL. Expect busy=0, no pulses, and mins back to 0xFF with maxes at 0.
